// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store access sequencer:
//   - FSM state encoding (IDLE, BEAT0, BEAT1, WAIT, RESP)
//   - funct3[1:0] access-size codes (log2 of the byte count)
//   - span_mask(): byte-lane span of an access, sized for the widest word
//     (8 lanes), so both the 32- and 64-bit builds can share it.
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BEAT0 = 3'd1;
  localparam logic [2:0] ST_BEAT1 = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int MAX_BYTES = 8;

  // Lanes touched by an access of 2**sz bytes starting at byte offset off,
  // across two consecutive words (low word in the low half).
  function automatic logic [2*MAX_BYTES-1:0] span_mask(input logic [1:0] sz,
                                                       input logic [2:0] off);
    logic [2*MAX_BYTES-1:0] base;
    base = (16'd1 << (4'd1 << sz)) - 16'd1;
    return base << off;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational lane steering for one access.
//   i_funct3     : RISC-V funct3 ([1:0] size, [2] unsigned load)
//   i_offset     : byte offset of the access inside its first word
//   i_wdata      : store data, LSB-justified
//   i_rdata_lo   : read data of the first word of the access
//   i_rdata_hi   : read data of the second word (zero when not split)
//   o_mask_lo/hi : byte-lane masks of the first / second word
//   o_wdata_lo/hi: store data placed on its lanes in the first / second word
//   o_rdata_ext  : extracted load value, sign- or zero-extended to WIDTH
// ---------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int BYTES = WIDTH / 8,
  localparam int OFF_W = $clog2(BYTES)
) (
  input  logic [2:0]       i_funct3,
  input  logic [OFF_W-1:0] i_offset,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [WIDTH-1:0] i_rdata_lo,
  input  logic [WIDTH-1:0] i_rdata_hi,
  output logic [BYTES-1:0] o_mask_lo,
  output logic [BYTES-1:0] o_mask_hi,
  output logic [WIDTH-1:0] o_wdata_lo,
  output logic [WIDTH-1:0] o_wdata_hi,
  output logic [WIDTH-1:0] o_rdata_ext
);

  localparam int SPAN_W = 2 * BYTES;

  logic [SPAN_W-1:0]  w_span;
  logic [BYTES-1:0]   w_lane_keep;
  logic [WIDTH-1:0]   w_keep;
  logic [OFF_W+2:0]   w_shamt;
  logic [2*WIDTH-1:0] w_wshift;
  logic [WIDTH-1:0]   w_rshift;
  logic               w_sign;

  always_comb begin
    w_span      = SPAN_W'(span_mask(i_funct3[1:0], 3'(i_offset)));
    // Lanes of the access once LSB-justified; doubles as the truncation
    // mask for store data and the keep mask for load data.
    w_lane_keep = BYTES'(span_mask(i_funct3[1:0], 3'd0));
    w_keep      = '0;
    for (int b = 0; b < BYTES; b++) begin
      w_keep[b*8 +: 8] = {8{w_lane_keep[b]}};
    end

    w_shamt  = {i_offset, 3'b000};
    w_wshift = {{WIDTH{1'b0}}, i_wdata & w_keep} << w_shamt;
    w_rshift = WIDTH'({i_rdata_hi, i_rdata_lo} >> w_shamt);

    // w_keep is a contiguous run from bit 0, so w_keep & ~(w_keep >> 1)
    // isolates its top bit: the sign bit of the loaded value.
    w_sign = (~i_funct3[2]) & (|(w_rshift & w_keep & ~(w_keep >> 1)));

    o_mask_lo   = w_span[BYTES-1:0];
    o_mask_hi   = w_span[SPAN_W-1:BYTES];
    o_wdata_lo  = w_wshift[WIDTH-1:0];
    o_wdata_hi  = w_wshift[2*WIDTH-1:WIDTH];
    o_rdata_ext = (w_rshift & w_keep) | (w_sign ? ~w_keep : '0);
  end

endmodule

// File: rtl/lsu_access_sequencer.sv
// ---------------------------------------------------------------------------
// lsu_access_sequencer
// Load/store alignment and sequencing between the memory stage and a
// word-organised, byte-masked synchronous data memory. Accesses crossing a
// word boundary are issued as two beats (or rejected when misaligned
// support is disabled). One request is in flight at a time.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : request present            req_ready : accepting (IDLE)
//   req_we       : 1 = store, 0 = load        req_funct3: size / unsigned
//   req_addr     : byte address               req_wdata : LSB-justified data
//   mem_en       : memory beat this cycle     mem_addr  : word address
//   mem_we       : byte write mask            mem_wdata : lane-aligned data
//   mem_rdata    : read data, one cycle after mem_en
//   resp_valid   : one-cycle completion       resp_err  : rejected access
//   resp_rdata   : extended load data (0 for stores and errors)
//
// All outputs decode from registered state only; req_* never reaches mem_*
// combinationally.
// ---------------------------------------------------------------------------
module lsu_access_sequencer
  import lsu_pkg::*;
#(
  parameter  int WIDTH            = 32,
  parameter  int ADDR_W           = 32,
  parameter  int ALLOW_MISALIGNED = 1,
  localparam int BYTES            = WIDTH / 8,
  localparam int OFF_W            = $clog2(BYTES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [2:0]              req_funct3,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [WIDTH-1:0]        req_wdata,
  output logic                    mem_en,
  output logic [ADDR_W-OFF_W-1:0] mem_addr,
  output logic [BYTES-1:0]        mem_we,
  output logic [WIDTH-1:0]        mem_wdata,
  input  logic [WIDTH-1:0]        mem_rdata,
  output logic                    resp_valid,
  output logic                    resp_err,
  output logic [WIDTH-1:0]        resp_rdata
);

  localparam int WA_W  = ADDR_W - OFF_W;
  localparam bit HAS_D = (WIDTH == 64);

  // Control state (reset)
  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic              r_err;

  // Latched request and load data (no reset needed: outputs are gated by
  // state, and every field is rewritten on accept)
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [WIDTH-1:0]  r_wdata;
  logic [WIDTH-1:0]  r_rd0;
  logic [WIDTH-1:0]  r_rdata;

  // Request classification
  logic [OFF_W-1:0]  w_align_mask;
  logic              w_illegal;
  logic              w_misal;
  logic              w_reject;

  // Lane steering of the latched request
  logic [WA_W-1:0]   w_word;
  logic              w_cross;
  logic [BYTES-1:0]  w_mask_lo;
  logic [BYTES-1:0]  w_mask_hi;
  logic [WIDTH-1:0]  w_wdata_lo;
  logic [WIDTH-1:0]  w_wdata_hi;
  logic [WIDTH-1:0]  w_rd_lo;
  logic [WIDTH-1:0]  w_rd_hi;
  logic [WIDTH-1:0]  w_rdata_ext;
  logic              w_beat0;
  logic              w_beat1;

  // Accept-time checks: illegal encodings, and offsets that are not a
  // multiple of the access size.
  always_comb begin
    w_align_mask = '0;
    for (int b = 0; b < OFF_W; b++) begin
      w_align_mask[b] = (b < int'(req_funct3[1:0]));
    end
    w_illegal = ((req_funct3[1:0] == SZ_D) & ~HAS_D) | (req_we & req_funct3[2]);
    w_misal   = (req_addr[OFF_W-1:0] & w_align_mask) != '0;
    w_reject  = w_illegal | ((ALLOW_MISALIGNED == 0) & w_misal);
  end

  assign w_word  = r_addr[ADDR_W-1:OFF_W];
  assign w_cross = (w_mask_hi != '0);

  // In WAIT the bus carries the last read: the only word for a single-beat
  // load, or the second word of a split load (first word held in r_rd0).
  assign w_rd_lo = w_cross ? r_rd0 : mem_rdata;
  assign w_rd_hi = w_cross ? mem_rdata : '0;

  lsu_lane_align #(
    .WIDTH (WIDTH)
  ) u_align (
    .i_funct3    (r_funct3),
    .i_offset    (r_addr[OFF_W-1:0]),
    .i_wdata     (r_wdata),
    .i_rdata_lo  (w_rd_lo),
    .i_rdata_hi  (w_rd_hi),
    .o_mask_lo   (w_mask_lo),
    .o_mask_hi   (w_mask_hi),
    .o_wdata_lo  (w_wdata_lo),
    .o_wdata_hi  (w_wdata_hi),
    .o_rdata_ext (w_rdata_ext)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid) w_state_nxt = w_reject ? ST_RESP : ST_BEAT0;
      ST_BEAT0: w_state_nxt = w_cross ? ST_BEAT1 : (r_we ? ST_RESP : ST_WAIT);
      ST_BEAT1: w_state_nxt = r_we ? ST_RESP : ST_WAIT;
      ST_WAIT:  w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && req_valid) r_err <= w_reject;
    end
  end

  // Request and load-data registers
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && req_valid) begin
      r_we     <= req_we;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_rdata  <= '0;
    end
    if (r_state == ST_BEAT1) r_rd0 <= mem_rdata;
    if (r_state == ST_WAIT)  r_rdata <= w_rdata_ext;
  end

  // Output decode
  assign w_beat0 = (r_state == ST_BEAT0);
  assign w_beat1 = (r_state == ST_BEAT1);

  assign req_ready  = (r_state == ST_IDLE);
  assign mem_en     = w_beat0 | w_beat1;
  assign mem_addr   = w_beat0 ? w_word : (w_beat1 ? w_word + WA_W'(1) : '0);
  assign mem_we     = (w_beat0 & r_we) ? w_mask_lo :
                      ((w_beat1 & r_we) ? w_mask_hi : '0);
  assign mem_wdata  = w_beat0 ? w_wdata_lo : (w_beat1 ? w_wdata_hi : '0);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_err   = resp_valid & r_err;
  assign resp_rdata = resp_valid ? r_rdata : '0;

endmodule

// File: tb/tb_lsu_access_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lsu_access_sequencer
// Three instances: 32-bit with split support, 64-bit with split support,
// 32-bit rejecting misaligned accesses. Requests go to one instance at a
// time; a byte-level reference model pushes the expected beats and the
// expected response into queues, and a monitor pops them as the DUT acts.
// ---------------------------------------------------------------------------
module tb_lsu_access_sequencer;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [ND-1:0] vld;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [63:0]   req_wdata;
  logic [63:0]   rd [ND];

  wire [ND-1:0] rdy, m_en, r_v, r_e;
  wire [29:0]   a0, a2;
  wire [28:0]   a1;
  wire [3:0]    we0, we2;
  wire [7:0]    we1;
  wire [31:0]   wd0, wd2, rr0, rr2;
  wire [63:0]   wd1, rr1;

  wire [31:0] m_addr [ND];
  wire [7:0]  m_we   [ND];
  wire [63:0] m_wd   [ND];
  wire [63:0] r_d    [ND];

  assign m_addr[0] = {2'b00, a0};
  assign m_addr[1] = {3'b000, a1};
  assign m_addr[2] = {2'b00, a2};
  assign m_we[0]   = {4'h0, we0};
  assign m_we[1]   = we1;
  assign m_we[2]   = {4'h0, we2};
  assign m_wd[0]   = {32'h0, wd0};
  assign m_wd[1]   = wd1;
  assign m_wd[2]   = {32'h0, wd2};
  assign r_d[0]    = {32'h0, rr0};
  assign r_d[1]    = rr1;
  assign r_d[2]    = {32'h0, rr2};

  lsu_access_sequencer #(.WIDTH(32), .ADDR_W(32), .ALLOW_MISALIGNED(1)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .mem_en(m_en[0]), .mem_addr(a0),
    .mem_we(we0), .mem_wdata(wd0), .mem_rdata(rd[0][31:0]),
    .resp_valid(r_v[0]), .resp_err(r_e[0]), .resp_rdata(rr0));

  lsu_access_sequencer #(.WIDTH(64), .ADDR_W(32), .ALLOW_MISALIGNED(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .mem_en(m_en[1]), .mem_addr(a1),
    .mem_we(we1), .mem_wdata(wd1), .mem_rdata(rd[1]),
    .resp_valid(r_v[1]), .resp_err(r_e[1]), .resp_rdata(rr1));

  lsu_access_sequencer #(.WIDTH(32), .ADDR_W(32), .ALLOW_MISALIGNED(0)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .mem_en(m_en[2]), .mem_addr(a2),
    .mem_we(we2), .mem_wdata(wd2), .mem_rdata(rd[2][31:0]),
    .resp_valid(r_v[2]), .resp_err(r_e[2]), .resp_rdata(rr2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Memory model: sparse, per instance; untouched words read a pattern.
  logic [63:0] mem [longint];

  function automatic longint key(input int d, input logic [31:0] w);
    return (longint'(d) << 40) | longint'(w);
  endfunction

  function automatic logic [63:0] mem_get(input int d, input logic [31:0] w);
    if (mem.exists(key(d, w))) return mem[key(d, w)];
    return {w * 32'h9E37_79B1, w ^ 32'h5A5A_C3C3};
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (m_en[d] === 1'b1) begin
        logic [63:0] w;
        w = mem_get(d, m_addr[d]);
        rd[d] <= w;
        for (int l = 0; l < 8; l++)
          if (m_we[d][l]) w[l*8 +: 8] = m_wd[d][l*8 +: 8];
        if (m_we[d] != 8'h0) mem[key(d, m_addr[d])] = w;
      end
    end
  end

  typedef struct { int d; int c; logic [31:0] a; logic [7:0] we; logic [63:0] wd; bit st; } beat_t;
  typedef struct { int d; int c; bit e; logic [63:0] rdat; } resp_t;
  beat_t bq[$];
  resp_t rq[$];

  // Byte-level reference: each byte k of the access lands at absolute
  // position o+k, i.e. word (o+k)/BYTES, lane (o+k)%BYTES.
  function automatic void model(input int d, input bit we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [63:0] wd);
    int          nby, offw, n, o, nb, pos, bt, ln, t;
    bit          am, err;
    logic [31:0] word, wmask;
    logic [7:0]  bm [2];
    logic [63:0] bw [2];
    logic [63:0] mw, rv;
    nby   = (d == 1) ? 8 : 4;
    offw  = (d == 1) ? 3 : 2;
    am    = (d != 2);
    n     = 1 << f3[1:0];
    o     = int'(a[2:0]) % nby;
    t     = cyc;
    err   = ((f3[1:0] == 2'd3) && nby == 4) || (we && f3[2]) || (!am && (o % n) != 0);
    word  = a >> offw;
    wmask = 32'hFFFF_FFFF >> offw;
    if (err) begin
      rq.push_back('{d, t + 1, 1'b1, 64'h0});
      return;
    end
    bm[0] = 8'h0; bm[1] = 8'h0; bw[0] = 64'h0; bw[1] = 64'h0; rv = 64'h0;
    nb = (o + n > nby) ? 2 : 1;
    for (int k = 0; k < n; k++) begin
      pos = o + k;
      bt  = pos / nby;
      ln  = pos % nby;
      mw  = mem_get(d, (word + 32'(bt)) & wmask);
      bm[bt][ln] = 1'b1;
      bw[bt][ln*8 +: 8] = wd[k*8 +: 8];
      rv[k*8 +: 8] = mw[ln*8 +: 8];
    end
    if (!f3[2] && rv[n*8-1])
      for (int k = n; k < nby; k++) rv[k*8 +: 8] = 8'hFF;
    for (int b = 0; b < nb; b++)
      bq.push_back('{d, t + 1 + b, (word + 32'(b)) & wmask, we ? bm[b] : 8'h0, bw[b], we});
    if (we) rq.push_back('{d, t + 1 + nb, 1'b0, 64'h0});
    else    rq.push_back('{d, t + 2 + nb, 1'b0, rv});
  endfunction

  // Monitor
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (m_en[d] === 1'b1) begin
        if (bq.size() == 0) chk("unexp_beat", m_en[d], 1'b0);
        else begin
          beat_t e;
          e = bq.pop_front();
          chk("beat_dut", d, e.d);
          chk("beat_cyc", cyc, e.c);
          chk("mem_addr", m_addr[d], e.a);
          chk("mem_we", m_we[d], e.we);
          if (e.st) chk("mem_wdata", m_wd[d], e.wd);
        end
      end
      if (r_v[d] === 1'b1) begin
        if (rq.size() == 0) chk("unexp_resp", r_v[d], 1'b0);
        else begin
          resp_t r;
          r = rq.pop_front();
          chk("resp_dut", d, r.d);
          chk("resp_cyc", cyc, r.c);
          chk("resp_err", r_e[d], r.e);
          chk("resp_rdata", r_d[d], r.rdat);
          chk("ready_in_resp", rdy[d], 1'b0);
        end
      end
    end
  end

  task automatic drain();
    int k;
    k = 0;
    while ((bq.size() != 0 || rq.size() != 0) && k < 16) begin
      @(posedge clk);
      k++;
    end
    chk("beats_left", bq.size(), 0);
    chk("resps_left", rq.size(), 0);
    bq.delete();
    rq.delete();
  endtask

  task automatic do_req(input int d, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [63:0] wd);
    @(posedge clk); #1;
    model(d, we, f3, a, wd);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    vld[d] = 1'b1;
    @(negedge clk);
    chk("req_ready", rdy[d], 1'b1);
    @(posedge clk); #1;
    vld[d] = 1'b0;
    drain();
  endtask

  task automatic chk_reset_vals();
    for (int d = 0; d < ND; d++) begin
      chk("rst_ready", rdy[d], 1'b1);
      chk("rst_mem_en", m_en[d], 1'b0);
      chk("rst_mem_we", m_we[d], 8'h0);
      chk("rst_mem_addr", m_addr[d], 32'h0);
      chk("rst_mem_wdata", m_wd[d], 64'h0);
      chk("rst_resp_valid", r_v[d], 1'b0);
      chk("rst_resp_err", r_e[d], 1'b0);
      chk("rst_resp_rdata", r_d[d], 64'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got cycle %0d, want < 20000", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1; vld = '0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 64'h0;
    for (int d = 0; d < ND; d++) rd[d] = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;

    mem[key(0, 32'h800)] = 64'h0000_0000_8012_3456;
    mem[key(0, 32'h801)] = 64'h0000_0000_1234_56FF;

    // 32-bit, split allowed
    do_req(0, 1, 3'b000, 32'h0000_1003, 64'hAB);
    do_req(0, 1, 3'b010, 32'h0000_1006, 64'h1122_3344);
    do_req(0, 0, 3'b001, 32'h0000_2003, 64'h0);
    do_req(0, 0, 3'b101, 32'h0000_2003, 64'h0);
    do_req(0, 0, 3'b000, 32'h0000_1003, 64'h0);
    do_req(0, 0, 3'b100, 32'h0000_1007, 64'h0);
    do_req(0, 0, 3'b010, 32'h0000_1008, 64'h0);
    do_req(0, 0, 3'b011, 32'h0000_1000, 64'h0);
    do_req(0, 1, 3'b100, 32'h0000_1000, 64'h55);
    do_req(0, 1, 3'b001, 32'hFFFF_FFFF, 64'hBEEF);
    do_req(0, 0, 3'b010, 32'hFFFF_FFFE, 64'h0);
    do_req(0, 1, 3'b010, 32'h0000_2000, 64'hDEAD_BEEF);
    // 64-bit, split allowed
    do_req(1, 1, 3'b011, 32'hFFFF_FFFC, 64'h0123_4567_89AB_CDEF);
    do_req(1, 0, 3'b011, 32'hFFFF_FFFC, 64'h0);
    do_req(1, 0, 3'b010, 32'h0000_1006, 64'h0);
    do_req(1, 0, 3'b100, 32'h0000_1005, 64'h0);
    do_req(1, 0, 3'b110, 32'h0000_1004, 64'h0);
    do_req(1, 1, 3'b001, 32'h0000_0007, 64'hA55A);
    do_req(1, 1, 3'b010, 32'h0000_0010, 64'hCAFE_F00D);
    // 32-bit, misaligned rejected
    do_req(2, 0, 3'b010, 32'h0000_0002, 64'h0);
    do_req(2, 0, 3'b001, 32'h0000_0001, 64'h0);
    do_req(2, 1, 3'b010, 32'h0000_0004, 64'h8765_4321);
    do_req(2, 0, 3'b010, 32'h0000_0004, 64'h0);
    do_req(2, 1, 3'b001, 32'h0000_0006, 64'hF00F);
    do_req(2, 0, 3'b101, 32'h0000_0006, 64'h0);
    do_req(2, 1, 3'b000, 32'h0000_0003, 64'h7E);
    do_req(2, 0, 3'b011, 32'h0000_0000, 64'h0);

    // Reset during BEAT0 of a split store: only the first beat may appear
    @(posedge clk); #1;
    t = cyc;
    bq.push_back('{0, t + 1, 32'h401, 8'h0C, 64'h3344_0000, 1'b1});
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_1006;
    req_wdata = 64'h1122_3344;
    vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_vals();
    repeat (5) @(posedge clk);
    chk("beats_left", bq.size(), 0);
    bq.delete();
    do_req(0, 1, 3'b010, 32'h0000_1006, 64'h5566_7788);
    do_req(0, 0, 3'b010, 32'h0000_1006, 64'h0);

    // Random mix across all instances
    for (int i = 0; i < 60; i++) begin
      do_req($urandom_range(0, ND - 1), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), {20'h00003, 12'($urandom)} ^ {$urandom_range(0, 1) == 1 ? 32'hFFFF_C000 : 32'h0},
             {$urandom, $urandom});
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_access_sequencer.md
Name: lsu_access_sequencer

Overview:
Parametrised load/store alignment and sequencing unit between the pipeline memory stage and a word-organised, byte-masked synchronous data memory. It generates byte-lane masks and aligned write data for SB/SH/SW (SD when WIDTH=64). It extracts and sign/zero-extends load data. Accesses that cross a word boundary are split into two memory beats under an FSM with a valid/ready handshake, or rejected when misaligned support is disabled.

Parameters:
WIDTH, 32, memory word width in bits; must be 32 or 64
ADDR_W, 32, byte-address width
ALLOW_MISALIGNED, 1, 1 = split boundary-crossing accesses into two beats; 0 = reject any access whose offset is not a multiple of its size
BYTES, WIDTH/8, derived; lanes per word
OFF_W, log2(BYTES), derived; offset bits

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept (IDLE only)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3; [1:0] size log2 bytes, [2] unsigned load
req_addr  input  ADDR_W  byte address
req_wdata  input  WIDTH  store data, LSB-justified
mem_en  output  1  memory access this cycle
mem_addr  output  ADDR_W-OFF_W  word address
mem_we  output  BYTES  byte write mask (all 0 for loads)
mem_wdata  output  WIDTH  lane-aligned write data
mem_rdata  input  WIDTH  read data, valid 1 cycle after mem_en
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  misaligned/illegal; qualified by resp_valid
resp_rdata  output  WIDTH  extended load data (0 for stores/errors)

Behaviour:
- Reset: state IDLE; req_ready=1, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_err=0, resp_rdata=0. Reset mid-operation aborts; no memory beat and no response after the reset cycle.
- All outputs are registered or decoded from registered state; no combinational path from req_* to mem_*.
- Size n = 1<<funct3[1:0]; size 3 with WIDTH=32, or funct3[2]=1 on a store, is illegal.
- Offset o = addr[OFF_W-1:0]. Mask: span = ((1<<n)-1)<<o over 2*BYTES bits; lo = span[BYTES-1:0], hi = span[2*BYTES-1:BYTES]. Data: (wdata truncated to n bytes) << 8*o over 2*WIDTH bits, split the same way. cross = (hi != 0).
- States:
  - IDLE: accept on req_valid & req_ready and latch request. Illegal, or misaligned with ALLOW_MISALIGNED=0 -> RESP with err=1, no memory access. Otherwise -> BEAT0.
  - BEAT0: mem_en=1, mem_addr=word, mem_we=lo (if store), mem_wdata=low half. Next: cross -> BEAT1; load -> WAIT; store -> RESP.
  - BEAT1: mem_en=1, mem_addr=word+1 (wraps modulo 2^(ADDR_W-OFF_W)), mem_we=hi, mem_wdata=high half; capture mem_rdata as rd0 (load). Next: load -> WAIT, store -> RESP.
  - WAIT: capture mem_rdata as last read; merge {rd1,rd0} (or rd0 alone) >> 8*o, keep n bytes, extend with funct3[2]. -> RESP.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE.
- req_ready=1 only in IDLE.
- Latency (accept at cycle T):
  - aligned store: beat T+1, resp T+2
  - split store: beats T+1/T+2, resp T+3
  - aligned load: resp T+3
  - split load: resp T+4
  - error: resp T+1
- Store response: resp_rdata=0. Error response: mem_en never asserted.

Decomposition:
- Shared package lsu_pkg: FSM state encoding (IDLE, BEAT0, BEAT1, WAIT, RESP), funct3 size constants (SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3), function for span mask.
- One sub-module, lsu_lane_align: purely combinational. Produces lo/hi masks, split write data, and load extract/extend from (funct3, offset, data).

Test Plan:
- WIDTH=32, SB addr 0x1003 data 0xAB -> beat T+1: mem_addr 0x400, mem_we 4'b1000, mem_wdata 0xAB000000; resp T+2, err=0.
- WIDTH=32, SW addr 0x1006 data 0x11223344, ALLOW_MISALIGNED=1 -> beat0 addr 0x401 we 4'b1100 wdata 0x33440000; beat1 addr 0x402 we 4'b0011 wdata 0x00001122; resp T+3.
- WIDTH=32, LH addr 0x2003, mem[0x800]=0x80xxxxxx, mem[0x801]=0xxxxxxxFF -> two read beats; resp_rdata 0xFFFFFF80 at T+4. Same access as LHU -> 0x0000FF80.
- ALLOW_MISALIGNED=0, LW addr 0x2 -> resp_valid T+1, resp_err=1, mem_en never high.
- WIDTH=64, SD addr 0xFFFFFFFC -> beats at word 0x1FFFFFFF then 0x0 (wrap); masks 8'hF0 / 8'h0F.
- rst asserted during BEAT0 of a split store -> no BEAT1, no resp_valid; outputs at reset values next cycle; next request behaves normally.
